// File: rtl/meter_cmd_sequencer.sv
// Parking meter front end: edge-detects buttons, generates the 1 s tick, queues
// events and issues one ADD/LOAD/DEC command at a time over valid/ready.
module meter_cmd_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 50,
  parameter int unsigned VAL_W         = 14,
  parameter int unsigned AMT1          = 60,
  parameter int unsigned AMT2          = 120,
  parameter int unsigned AMT3          = 180,
  parameter int unsigned AMT4          = 300,
  parameter int unsigned LOAD1         = 15,
  parameter int unsigned LOAD2         = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add1,
  input  logic             add2,
  input  logic             add3,
  input  logic             add4,
  input  logic             rst1,
  input  logic             rst2,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [VAL_W-1:0] cmd_value,
  output logic             drop_err,
  output logic             tick_ovr,
  output logic             busy
);

  localparam int unsigned TCW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  logic [5:0]       btn, btn_q, press;
  logic [TCW-1:0]   tick_cnt;
  logic             tick_evt, tick_pend, tick_n;
  logic [3:0][1:0]  add_cnt, add_n;
  logic             load1_p, load2_p, load1_n, load2_n;
  logic             slot, flush, drop_n, busy_n;
  logic             g_l1, g_l2, g_tick;
  logic [3:0]       g_add;
  logic             valid_n;
  logic [1:0]       op_n;
  logic [VAL_W-1:0] val_n;

  assign btn      = {rst2, rst1, add4, add3, add2, add1};
  assign press    = btn & ~btn_q;
  assign tick_evt = (tick_cnt == TCW'(TICKS_PER_SEC - 1));

  // Grant, queue update and next command
  always_comb begin
    slot   = !cmd_valid || cmd_ready;
    g_l1   = 1'b0;
    g_l2   = 1'b0;
    g_tick = 1'b0;
    g_add  = 4'b0;
    if (slot) begin
      if (load1_p)              g_l1     = 1'b1;
      else if (load2_p)         g_l2     = 1'b1;
      else if (tick_pend)       g_tick   = 1'b1;
      else if (add_cnt[3] != 0) g_add[3] = 1'b1;
      else if (add_cnt[2] != 0) g_add[2] = 1'b1;
      else if (add_cnt[1] != 0) g_add[1] = 1'b1;
      else if (add_cnt[0] != 0) g_add[0] = 1'b1;
    end

    flush  = press[4] | press[5];
    drop_n = 1'b0;
    add_n  = add_cnt;
    for (int i = 0; i < 4; i++) begin
      if (flush) begin
        add_n[i] = 2'd0;
      end else if (press[i] && !g_add[i]) begin
        if (add_cnt[i] == 2'd3) drop_n   = 1'b1;
        else                    add_n[i] = add_cnt[i] + 2'd1;
      end else if (g_add[i] && !press[i]) begin
        add_n[i] = add_cnt[i] - 2'd1;
      end
    end

    // rst1 wins when both reset buttons rise together
    if (press[4])      load1_n = 1'b1;
    else if (press[5]) load1_n = 1'b0;
    else               load1_n = load1_p & ~g_l1;
    if (press[4])      load2_n = 1'b0;
    else if (press[5]) load2_n = 1'b1;
    else               load2_n = load2_p & ~g_l2;

    tick_n = tick_evt | (tick_pend & ~g_tick);

    valid_n = cmd_valid;
    op_n    = cmd_op;
    val_n   = cmd_value;
    if (slot) begin
      valid_n = g_l1 | g_l2 | g_tick | (|g_add);
      if (g_l1)          begin op_n = OP_LOAD; val_n = VAL_W'(LOAD1); end
      else if (g_l2)     begin op_n = OP_LOAD; val_n = VAL_W'(LOAD2); end
      else if (g_tick)   begin op_n = OP_DEC;  val_n = VAL_W'(1);     end
      else if (g_add[3]) begin op_n = OP_ADD;  val_n = VAL_W'(AMT4);  end
      else if (g_add[2]) begin op_n = OP_ADD;  val_n = VAL_W'(AMT3);  end
      else if (g_add[1]) begin op_n = OP_ADD;  val_n = VAL_W'(AMT2);  end
      else if (g_add[0]) begin op_n = OP_ADD;  val_n = VAL_W'(AMT1);  end
    end

    busy_n = valid_n | tick_n | load1_n | load2_n | (|add_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= '0;
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
      add_cnt   <= '0;
      load1_p   <= 1'b0;
      load2_p   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'b00;
      cmd_value <= '0;
      drop_err  <= 1'b0;
      tick_ovr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_q     <= btn;
      tick_cnt  <= tick_evt ? '0 : tick_cnt + TCW'(1);
      tick_pend <= tick_n;
      add_cnt   <= add_n;
      load1_p   <= load1_n;
      load2_p   <= load2_n;
      cmd_valid <= valid_n;
      cmd_op    <= op_n;
      cmd_value <= val_n;
      drop_err  <= drop_n;
      if (tick_evt && tick_pend) tick_ovr <= 1'b1;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_meter_cmd_sequencer.sv
// Directed bench for meter_cmd_sequencer; every expected value is hand-derived
// from edge counts after reset (tick pending after edge 50, DEC valid after 51).
module tb_meter_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        add1, add2, add3, add4, rst1, rst2;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_value;
  logic        drop_err, tick_ovr, busy;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;

  meter_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .add1(add1), .add2(add2), .add3(add3), .add4(add4),
    .rst1(rst1), .rst2(rst2),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_value(cmd_value), .drop_err(drop_err), .tick_ovr(tick_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic step_to(input int target);
    while (e < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
  endtask

  task automatic clear_inputs();
    {add1, add2, add3, add4, rst1, rst2} = 6'b0;
  endtask

  task automatic check_cmd(input string tag, input logic v, input logic [1:0] op,
                           input logic [13:0] val);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(v));
    if (v) begin
      check({tag, "_op"}, 32'(cmd_op), 32'(op));
      check({tag, "_value"}, 32'(cmd_value), 32'(val));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int adds;
    clear_inputs();
    cmd_ready = 1'b1;
    rst = 1'b1;

    // Reset state, then free-running tick
    do_reset();
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_op", 32'(cmd_op), 0);
    check("rst_value", 32'(cmd_value), 0);
    check("rst_drop", 32'(drop_err), 0);
    check("rst_ovr", 32'(tick_ovr), 0);
    check("rst_busy", 32'(busy), 0);
    step_to(50);
    check_cmd("t1_e50", 1'b0, 2'd0, 14'd0);
    check("t1_busy50", 32'(busy), 1);
    step();
    check_cmd("t1_e51", 1'b1, 2'd2, 14'd1);
    step();
    check_cmd("t1_e52", 1'b0, 2'd0, 14'd0);
    check("t1_busy52", 32'(busy), 0);
    step_to(100);
    check_cmd("t1_e100", 1'b0, 2'd0, 14'd0);
    step();
    check_cmd("t1_e101", 1'b1, 2'd2, 14'd1);
    check("t1_ovr", 32'(tick_ovr), 0);

    // add1 held through reset counts as one press; holding gives no repeats
    add1 = 1'b1;
    do_reset();
    step();
    check_cmd("t2_e1", 1'b0, 2'd0, 14'd0);
    check("t2_busy1", 32'(busy), 1);
    step();
    check_cmd("t2_e2", 1'b1, 2'd0, 14'd60);
    adds = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (cmd_valid && cmd_op == 2'd0) adds++;
    end
    check("t2_extra_adds", 32'(adds), 0);
    clear_inputs();

    // Saturation: one in output slot + 3 queued, 5th press dropped
    cmd_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      add4 = 1'b1;
      step();
      check("t3_drop_press", 32'(drop_err), (k == 4) ? 32'd1 : 32'd0);
      add4 = 1'b0;
      step();
      check("t3_drop_after", 32'(drop_err), 0);
    end
    check_cmd("t3_held", 1'b1, 2'd0, 14'd300);
    cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_cmd("t3_burst", 1'b1, 2'd0, 14'd300);
    end
    step();
    check_cmd("t3_done", 1'b0, 2'd0, 14'd0);
    check("t3_busy", 32'(busy), 0);
    clear_inputs();

    // rst2 flushes queued adds; LOAD2 then tick issue, nothing else
    cmd_ready = 1'b0;
    add1 = 1'b1;
    do_reset();
    step_to(43);
    add2 = 1'b1;
    step();
    add3 = 1'b1;
    step();
    rst2 = 1'b1;
    step();
    check_cmd("t4_hold46", 1'b1, 2'd0, 14'd60);
    step_to(50);
    check_cmd("t4_hold50", 1'b1, 2'd0, 14'd60);
    check("t4_busy50", 32'(busy), 1);
    cmd_ready = 1'b1;
    step();
    check_cmd("t4_load", 1'b1, 2'd1, 14'd150);
    step();
    check_cmd("t4_dec", 1'b1, 2'd2, 14'd1);
    step();
    check_cmd("t4_done", 1'b0, 2'd0, 14'd0);
    check("t4_busy", 32'(busy), 0);
    clear_inputs();

    // rst1+rst2 together while ADD 120 stalled
    cmd_ready = 1'b0;
    add2 = 1'b1;
    do_reset();
    step_to(3);
    rst1 = 1'b1;
    rst2 = 1'b1;
    step();
    check_cmd("t5_hold4", 1'b1, 2'd0, 14'd120);
    step_to(6);
    check_cmd("t5_hold6", 1'b1, 2'd0, 14'd120);
    cmd_ready = 1'b1;
    step();
    check_cmd("t5_load", 1'b1, 2'd1, 14'd15);
    step();
    check_cmd("t5_done", 1'b0, 2'd0, 14'd0);
    check("t5_busy", 32'(busy), 0);
    clear_inputs();

    // Long stall: DEC held, tick pending from edge 100, overrun at edge 150
    cmd_ready = 1'b0;
    do_reset();
    step_to(149);
    check_cmd("t6_held", 1'b1, 2'd2, 14'd1);
    check("t6_ovr149", 32'(tick_ovr), 0);
    step();
    check("t6_ovr150", 32'(tick_ovr), 1);
    step_to(160);
    check("t6_ovr160", 32'(tick_ovr), 1);
    do_reset();
    check("t6_rst_valid", 32'(cmd_valid), 0);
    check("t6_rst_ovr", 32'(tick_ovr), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_drop", 32'(drop_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
